xaui_link_sync_ctrl: RTL and testbench

//  Per-XAUI-port receive link controller, directly downstream of the XAUI MGT infrastructure (one instance per enabled port).

---
 rtl/xaui_link_sync_ctrl_if.sv | 23 ++
 rtl/xaui_link_sync_ctrl.sv | 146 ++++++++++++++
 tb/tb_xaui_link_sync_ctrl.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/xaui_link_sync_ctrl_if.sv
// Per-port XAUI MGT receive bundle: lane status/data into the link controller,
// per-lane reset and alignment controls back out to the transceiver.
interface xaui_link_sync_ctrl_if;
  logic [63:0] mgt_rxdata;
  logic [7:0]  mgt_rxcharisk;
  logic [7:0]  mgt_codevalid;
  logic [3:0]  mgt_rxlock;
  logic [3:0]  mgt_syncok;
  logic [3:0]  mgt_rxbufferr;
  logic [3:0]  mgt_rx_reset;
  logic [3:0]  mgt_enable_align;
  logic        mgt_enchansync;

  modport master (
    output mgt_rxdata, mgt_rxcharisk, mgt_codevalid, mgt_rxlock, mgt_syncok, mgt_rxbufferr,
    input  mgt_rx_reset, mgt_enable_align, mgt_enchansync
  );

  modport slave (
    input  mgt_rxdata, mgt_rxcharisk, mgt_codevalid, mgt_rxlock, mgt_syncok, mgt_rxbufferr,
    output mgt_rx_reset, mgt_enable_align, mgt_enchansync
  );
endinterface

// File: rtl/xaui_link_sync_ctrl.sv
// XAUI per-port receive link controller: sequences MGT reset, lock, comma sync and
// /A/ lane deskew, declares link_up, and retrains when link health degrades.
module xaui_link_sync_ctrl #(
  parameter int RESET_CYCLES = 16,
  parameter int SYNC_TIMEOUT = 65535,
  parameter int ALIGN_COUNT  = 4,
  parameter int ERR_THRESH   = 8,
  parameter int ERR_WINDOW   = 1024
) (
  input  logic                     mgt_clk,
  input  logic                     reset,
  xaui_link_sync_ctrl_if.slave     mgt,
  output logic                     link_up,
  output logic [2:0]               link_state,
  output logic [15:0]              link_drop_cnt
);

  localparam logic [2:0] ST_RST       = 3'd0;
  localparam logic [2:0] ST_WAIT_LOCK = 3'd1;
  localparam logic [2:0] ST_COMMA     = 3'd2;
  localparam logic [2:0] ST_BOND      = 3'd3;
  localparam logic [2:0] ST_UP        = 3'd4;

  localparam int TIMER_MAX = (SYNC_TIMEOUT > RESET_CYCLES) ? SYNC_TIMEOUT : RESET_CYCLES;
  localparam int TIMER_W   = $clog2(TIMER_MAX + 1);
  localparam int ALIGN_W   = $clog2(ALIGN_COUNT + 1);
  localparam int ERR_W     = $clog2(ERR_THRESH + 1);
  localparam int WIN_W     = $clog2(ERR_WINDOW + 1);

  logic [2:0]         state;
  logic [2:0]         next_state;
  logic [TIMER_W-1:0] timer;
  logic [ALIGN_W-1:0] align_cnt;
  logic [ERR_W-1:0]   err_cnt;
  logic [WIN_W-1:0]   win_cnt;

  logic [7:0] a_hit;
  logic [3:0] col_b0;
  logic [3:0] col_b1;
  logic       aligned;
  logic       misaligned;
  logic       all_lock;
  logic       all_sync;
  logic       err_now;
  logic       win_wrap;
  logic       drop;
  logic       rst_done;
  logic       timeout;
  logic       align_done;

  // Byte slot k of rxdata lines up with charisk/codevalid bit k (lane k/2, byte k%2).
  always_comb begin
    a_hit = '0;
    for (int k = 0; k < 8; k++) begin
      a_hit[k] = mgt.mgt_rxcharisk[k] && (mgt.mgt_rxdata[8*k +: 8] == 8'h7C);
    end
  end

  assign col_b0     = {a_hit[6], a_hit[4], a_hit[2], a_hit[0]};
  assign col_b1     = {a_hit[7], a_hit[5], a_hit[3], a_hit[1]};
  assign aligned    = (&col_b0) | (&col_b1);
  assign misaligned = ((|col_b0) & ~(&col_b0)) | ((|col_b1) & ~(&col_b1));
  assign all_lock   = &mgt.mgt_rxlock;
  assign all_sync   = &mgt.mgt_syncok;
  assign err_now    = ~(&mgt.mgt_codevalid);
  assign win_wrap   = (win_cnt == WIN_W'(ERR_WINDOW - 1));
  assign drop       = ~all_lock | ~all_sync | (|mgt.mgt_rxbufferr) | (err_cnt >= ERR_W'(ERR_THRESH));
  assign rst_done   = (timer == TIMER_W'(RESET_CYCLES - 1));
  assign timeout    = (timer == TIMER_W'(SYNC_TIMEOUT - 1));
  assign align_done = aligned && !misaligned && (align_cnt == ALIGN_W'(ALIGN_COUNT - 1));

  always_comb begin
    next_state = state;
    case (state)
      ST_RST:       if (rst_done) next_state = ST_WAIT_LOCK;
      ST_WAIT_LOCK: begin
        if (all_lock)     next_state = ST_COMMA;
        else if (timeout) next_state = ST_RST;
      end
      ST_COMMA: begin
        if (!all_lock)     next_state = ST_RST;
        else if (all_sync) next_state = ST_BOND;
        else if (timeout)  next_state = ST_RST;
      end
      ST_BOND: begin
        if (!all_lock || !all_sync) next_state = ST_RST;
        else if (align_done)        next_state = ST_UP;
        else if (timeout)           next_state = ST_RST;
      end
      ST_UP:        if (drop) next_state = ST_RST;
      default:      next_state = ST_RST;
    endcase
  end

  always_ff @(posedge mgt_clk) begin
    if (reset) begin
      state     <= ST_RST;
      timer     <= '0;
      align_cnt <= '0;
    end else begin
      state <= next_state;
      timer <= ((next_state != state) || (state == ST_UP)) ? '0 : timer + 1'b1;
      if (state != ST_BOND)  align_cnt <= '0;
      else if (misaligned)   align_cnt <= '0;
      else if (aligned)      align_cnt <= align_cnt + 1'b1;
    end
  end

  // An error seen in the wrap cycle is the first count of the new window.
  always_ff @(posedge mgt_clk) begin
    if (reset || (state != ST_UP)) begin
      win_cnt <= '0;
      err_cnt <= '0;
    end else begin
      win_cnt <= win_wrap ? '0 : win_cnt + 1'b1;
      if (win_wrap)                                      err_cnt <= ERR_W'(err_now);
      else if (err_now && (err_cnt < ERR_W'(ERR_THRESH))) err_cnt <= err_cnt + 1'b1;
    end
  end

  always_ff @(posedge mgt_clk) begin
    if (reset) begin
      link_drop_cnt <= '0;
    end else if ((state == ST_UP) && (next_state == ST_RST) && (link_drop_cnt != 16'hFFFF)) begin
      link_drop_cnt <= link_drop_cnt + 16'd1;
    end
  end

  // Outputs are registered from the state being entered so they line up with link_state.
  always_ff @(posedge mgt_clk) begin
    if (reset) begin
      mgt.mgt_rx_reset     <= 4'hF;
      mgt.mgt_enable_align <= 4'h0;
      mgt.mgt_enchansync   <= 1'b0;
      link_up              <= 1'b0;
    end else begin
      mgt.mgt_rx_reset     <= (next_state == ST_RST) ? 4'hF : 4'h0;
      mgt.mgt_enable_align <= (next_state >= ST_COMMA) ? 4'hF : 4'h0;
      mgt.mgt_enchansync   <= (next_state >= ST_BOND);
      link_up              <= (next_state == ST_UP);
    end
  end

  assign link_state = state;

endmodule

// File: tb/tb_xaui_link_sync_ctrl.sv
// Directed scoreboard bench for xaui_link_sync_ctrl: training, deskew, timeouts,
// error-window drops and reset override.
module tb_xaui_link_sync_ctrl;

  logic        mgt_clk = 1'b0;
  logic        reset;
  logic        link_up;
  logic [2:0]  link_state;
  logic [15:0] link_drop_cnt;

  xaui_link_sync_ctrl_if mif();

  xaui_link_sync_ctrl dut (
    .mgt_clk       (mgt_clk),
    .reset         (reset),
    .mgt           (mif.slave),
    .link_up       (link_up),
    .link_state    (link_state),
    .link_drop_cnt (link_drop_cnt)
  );

  always #5 mgt_clk = ~mgt_clk;

  typedef struct {
    string       tag;
    logic [28:0] vec;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;
  logic [15:0] exp_drops = 16'd0;

  // Packed as {state, link_up, rx_reset, enable_align, enchansync, drop_cnt}.
  function automatic logic [28:0] expect_vec(input logic [2:0] st, input logic [15:0] drops);
    return {st, (st == 3'd4), ((st == 3'd0) ? 4'hF : 4'h0), ((st >= 3'd2) ? 4'hF : 4'h0),
            (st >= 3'd3), drops};
  endfunction

  task automatic set_a(input logic [7:0] mask);
    logic [63:0] d;
    d = '0;
    for (int k = 0; k < 8; k++) begin
      if (mask[k]) d[8*k +: 8] = 8'h7C;
    end
    mif.mgt_rxdata    = d;
    mif.mgt_rxcharisk = mask;
  endtask

  task automatic apply_stimulus(input string tag, input logic [2:0] st, input logic [15:0] drops);
    exp_t e;
    e.tag = tag;
    e.vec = expect_vec(st, drops);
    exp_q.push_back(e);
    @(posedge mgt_clk);
  endtask

  task automatic check_output();
    exp_t        e;
    logic [28:0] obs;
    #1;
    obs = {link_state, link_up, mif.mgt_rx_reset, mif.mgt_enable_align, mif.mgt_enchansync,
           link_drop_cnt};
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $error("[TB] FAIL scoreboard_empty observed=%h expected=none", obs);
    end else begin
      e = exp_q.pop_front();
      assert (obs === e.vec) else begin
        errors++;
        $error("[TB] FAIL %s observed=%h expected=%h {state,up,rxrst,align,chsync,drops}",
               e.tag, obs, e.vec);
      end
    end
  endtask

  task automatic cycle(input string tag, input logic [2:0] st, input logic [15:0] drops);
    apply_stimulus(tag, st, drops);
    check_output();
  endtask

  // From a fresh RST entry with lock and sync already high, walk to BOND.
  task automatic to_bond();
    for (int i = 0; i < 15; i++) cycle("rst_hold", 3'd0, exp_drops);
    cycle("wait_lock", 3'd1, exp_drops);
    cycle("comma", 3'd2, exp_drops);
    cycle("bond", 3'd3, exp_drops);
  endtask

  task automatic columns();
    for (int k = 0; k < 4; k++) begin
      set_a(8'h00);
      for (int i = 0; i < 19; i++) cycle("bond_wait", 3'd3, exp_drops);
      set_a(8'h55);
      if (k == 3) cycle("up_entry", 3'd4, exp_drops);
      else        cycle("bond_col", 3'd3, exp_drops);
    end
    set_a(8'h00);
  endtask

  function automatic bit t5_err(input int i);
    return (i < 7) || ((i >= 2040) && (i <= 2053)) || ((i >= 3100) && (i <= 3107));
  endfunction

  initial begin
    reset                 = 1'b1;
    mif.mgt_rxdata        = '0;
    mif.mgt_rxcharisk     = '0;
    mif.mgt_codevalid     = 8'hFF;
    mif.mgt_rxlock        = 4'h0;
    mif.mgt_syncok        = 4'h0;
    mif.mgt_rxbufferr     = 4'h0;

    // T1: reset then RESET_CYCLES in RST
    repeat (3) cycle("t1_reset", 3'd0, 16'd0);
    reset = 1'b0;
    for (int i = 0; i < 15; i++) cycle("t1_rst_hold", 3'd0, 16'd0);
    cycle("t1_wait_lock", 3'd1, 16'd0);
    cycle("t1_wait_hold", 3'd1, 16'd0);

    // T2: lock, sync, four /A/ columns
    mif.mgt_rxlock = 4'hF;
    mif.mgt_syncok = 4'hF;
    cycle("t2_comma", 3'd2, 16'd0);
    cycle("t2_bond", 3'd3, 16'd0);
    columns();
    repeat (3) cycle("t2_up", 3'd4, 16'd0);

    // T4: elastic buffer error on lane 1 drops the link
    mif.mgt_rxbufferr = 4'b0010;
    exp_drops = 16'd1;
    cycle("t4_bufferr_drop", 3'd0, exp_drops);
    mif.mgt_rxbufferr = 4'h0;
    to_bond();
    columns();

    // T5: error window; index 0 is the first UP cycle, wraps at 1023, 2047, 3071
    for (int i = 0; i < 3108; i++) begin
      mif.mgt_codevalid = t5_err(i) ? ~(8'h01 << (i % 8)) : 8'hFF;
      cycle("t5_up", 3'd4, exp_drops);
    end
    mif.mgt_codevalid = 8'hFF;
    exp_drops = 16'd2;
    cycle("t5_err_drop", 3'd0, exp_drops);

    // T3: repeating A,A,A,A+misaligned,misaligned never deskews; BOND times out
    to_bond();
    for (int i = 0; i < 65535; i++) begin
      case (i % 5)
        3:       set_a(8'h75);
        4:       set_a(8'h65);
        default: set_a(8'h55);
      endcase
      if (i == 65534) cycle("t3_timeout", 3'd0, exp_drops);
      else            cycle("t3_bond", 3'd3, exp_drops);
    end
    set_a(8'h00);

    // T6: reset mid-BOND with three columns counted, a fourth presented
    to_bond();
    set_a(8'h55);
    repeat (3) cycle("t6_bond_cnt", 3'd3, exp_drops);
    reset = 1'b1;
    exp_drops = 16'd0;
    cycle("t6_reset", 3'd0, exp_drops);
    reset = 1'b0;
    set_a(8'h00);
    cycle("t6_after", 3'd0, exp_drops);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
